// File: rtl/mpu_mvu_engine.sv
// Weight-stationary matrix-vector unit. An N x N weight tile is loaded row by
// row, then activation vectors stream in and each one produces
// y[j] = sum_i a[i]*W[i][j] into its own accumulator entry. When every vector
// of the pass has been written back, the entries drain in order.
module mpu_mvu_engine #(
  parameter int N         = 8,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 32,
  parameter int ACC_DEPTH = 16,
  parameter int SIGNED    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       load_w,
  input  logic                       acc_mode,
  input  logic [$clog2(ACC_DEPTH):0] vec_count,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [N*DATA_W-1:0]        w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [N*DATA_W-1:0]        a_data,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [N*ACC_W-1:0]         r_data,
  output logic                       r_last,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf
);

  localparam int CNT_W  = $clog2(ACC_DEPTH) + 1;
  localparam int IDX_W  = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam int ROW_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;     // next weight row to write
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // vectors accepted this pass
  logic [CNT_W-1:0]    k_q, k_d;         // next entry to drain
  logic [CNT_W-1:0]    vc_q, vc_d;       // clamped vector count of this pass
  logic                mode_q, mode_d;   // 1: accumulate onto existing entries
  logic                ovf_q, ovf_d;
  logic                pipe_v_q;         // registered vector awaiting writeback
  logic [IDX_W-1:0]    pipe_idx_q;
  logic [N*DATA_W-1:0] pipe_a_q;
  logic [N*DATA_W-1:0] w_q   [N];
  logic [N*ACC_W-1:0]  acc_q [ACC_DEPTH];

  logic                w_hs, a_hs, r_hs;
  logic [CNT_W-1:0]    vc_clamped;
  logic [N*ACC_W-1:0]  wb_vec;
  logic                wb_ovf;

  assign w_ready    = (state_q == S_LOAD_W);
  assign a_ready    = (state_q == S_COMPUTE) && (cnt_q != vc_q);
  assign r_valid    = (state_q == S_DRAIN);
  assign r_last     = r_valid && (k_q == vc_q - CNT_W'(1));
  assign r_data     = r_valid ? acc_q[k_q[IDX_W-1:0]] : '0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH);
  assign ovf        = ovf_q;

  assign w_hs       = w_valid && w_ready;
  assign a_hs       = a_valid && a_ready;
  assign r_hs       = r_valid && r_ready;
  assign vc_clamped = (vec_count > CNT_W'(ACC_DEPTH)) ? CNT_W'(ACC_DEPTH) : vec_count;

  // Column sums of the registered vector against the tile, merged with the target entry.
  always_comb begin
    logic signed [DATA_W:0]   op_a, op_w;
    logic signed [PROD_W+1:0] prod_full;
    logic [PROD_W-1:0]        prod;
    logic [ACC_W-1:0]         col, base, sum;
    op_a      = '0;
    op_w      = '0;
    prod_full = '0;
    prod      = '0;
    col       = '0;
    base      = '0;
    sum       = '0;
    wb_vec    = '0;
    wb_ovf    = 1'b0;
    for (int j = 0; j < N; j++) begin
      col = '0;
      for (int i = 0; i < N; i++) begin
        // One guard bit carries the sign (SIGNED) or a zero, so a single signed multiply serves both modes.
        op_a = $signed({(SIGNED != 0) && pipe_a_q[i*DATA_W + DATA_W-1],
                        pipe_a_q[i*DATA_W +: DATA_W]});
        op_w = $signed({(SIGNED != 0) && w_q[i][j*DATA_W + DATA_W-1],
                        w_q[i][j*DATA_W +: DATA_W]});
        prod_full = op_a * op_w;
        prod      = prod_full[PROD_W-1:0];
        col = col + ((SIGNED != 0) ? {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod}
                                   : {{(ACC_W-PROD_W){1'b0}}, prod});
      end
      base = mode_q ? acc_q[pipe_idx_q][j*ACC_W +: ACC_W] : '0;
      sum  = base + col;
      wb_vec[j*ACC_W +: ACC_W] = sum;
      // Signed overflow: like-signed operands producing a result of the other sign.
      if ((base[ACC_W-1] == col[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]))
        wb_ovf = 1'b1;
    end
  end

  // Pass sequencing: load tile, accept vectors, drain entries, pulse done.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    vc_d    = vc_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    if (pipe_v_q && wb_ovf) ovf_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vc_d   = vc_clamped;
          mode_d = acc_mode;
          ovf_d  = 1'b0;
          row_d  = '0;
          cnt_d  = '0;
          k_d    = '0;
          if (vec_count == '0)  state_d = S_FINISH;
          else if (load_w)      state_d = S_LOAD_W;
          else                  state_d = S_COMPUTE;
        end
      end
      S_LOAD_W: begin
        if (w_hs) begin
          row_d = row_q + ROW_W'(1);
          if (row_q == ROW_W'(N-1)) state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        // Once the count is reached the last vector writes back this cycle, so DRAIN sees it.
        if (a_hs)                cnt_d   = cnt_q + CNT_W'(1);
        else if (cnt_q == vc_q)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_hs) begin
          k_d = k_q + CNT_W'(1);
          if (r_last) state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control state, the one-stage vector pipeline and the storage arrays.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      vc_q       <= '0;
      mode_q     <= 1'b0;
      ovf_q      <= 1'b0;
      pipe_v_q   <= 1'b0;
      pipe_idx_q <= '0;
      pipe_a_q   <= '0;
      // NOTE: the tile and accumulator bank are cleared on reset because entries are
      // visible on r_data and are read back by accumulate passes; they are flops, not RAM.
      for (int r = 0; r < N; r++)         w_q[r]   <= '0;
      for (int d = 0; d < ACC_DEPTH; d++) acc_q[d] <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      vc_q     <= vc_d;
      mode_q   <= mode_d;
      ovf_q    <= ovf_d;
      pipe_v_q <= a_hs;
      if (a_hs) begin
        pipe_idx_q <= cnt_q[IDX_W-1:0];
        pipe_a_q   <= a_data;
      end
      if (w_hs)     w_q[row_q]        <= w_data;
      if (pipe_v_q) acc_q[pipe_idx_q] <= wb_vec;
    end
  end

endmodule

// File: tb/tb_mpu_mvu_engine.sv
// Directed bench for mpu_mvu_engine: identity, saturating-magnitude, accumulate
// doubling, stalled streams, count clamp, empty pass, abort by reset, and an
// 18-bit accumulator build that overflows.
module tb_mpu_mvu_engine;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int D  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, load_w, acc_mode;
  logic [4:0]      vec_count;
  logic            w_valid, w_ready, a_valid, a_ready;
  logic [N*DW-1:0] w_data, a_data;
  logic            r_valid, r_ready, r_last, busy, done, ovf;
  logic [N*AW-1:0] r_data;
  logic            w_ready18, a_ready18, r_valid18, r_last18, busy18, done18, ovf18;
  logic [N*18-1:0] r_data18;

  mpu_mvu_engine dut (
    .clk(clk), .rst(rst), .start(start), .load_w(load_w), .acc_mode(acc_mode),
    .vec_count(vec_count), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .r_valid(r_valid),
    .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .busy(busy), .done(done),
    .ovf(ovf)
  );

  // Narrow-accumulator build driven by the same stimulus; control timing is identical.
  mpu_mvu_engine #(.ACC_W(18)) dut18 (
    .clk(clk), .rst(rst), .start(start), .load_w(load_w), .acc_mode(acc_mode),
    .vec_count(vec_count), .w_valid(w_valid), .w_ready(w_ready18), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready18), .a_data(a_data), .r_valid(r_valid18),
    .r_ready(r_ready), .r_data(r_data18), .r_last(r_last18), .busy(busy18), .done(done18),
    .ovf(ovf18)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int          w_m   [N][N];
  int          a_m   [D][N];
  longint      acc_m [D][N];
  logic [255:0] res   [D];
  logic [143:0] res18 [D];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  function automatic logic [255:0] exp_vec(input int k);
    logic [255:0] v;
    longint t;
    v = '0;
    for (int j = 0; j < N; j++) begin
      t = acc_m[k][j];
      v[j*AW +: AW] = t[31:0];
    end
    return v;
  endfunction

  function automatic logic [255:0] splat32(input int val);
    logic [255:0] v;
    for (int j = 0; j < N; j++) v[j*AW +: AW] = val;
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) w_m[i][j] = 0;
    for (int k = 0; k < D; k++) for (int j = 0; j < N; j++) acc_m[k][j] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; load_w = 1'b0; acc_mode = 1'b0; vec_count = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; r_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_model();
  endtask

  task automatic send_weights(input bit stalls);
    int r = 0, budget = 0, t;
    bit hs;
    while (r < N && budget < 2000) begin
      w_valid = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int j = 0; j < N; j++) begin
        t = w_m[r][j];
        w_data[j*DW +: DW] = t[7:0];
      end
      hs = w_valid && w_ready;
      @(negedge clk);
      if (hs) r++;
      budget++;
    end
    w_valid = 1'b0;
    if (r < N) check("timeout_weights", 0, 1);
  endtask

  task automatic send_acts(input int vc, input bit stalls);
    int k = 0, budget = 0, t;
    bit hs;
    while (k < vc && budget < 4000) begin
      a_valid = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int i = 0; i < N; i++) begin
        t = a_m[k][i];
        a_data[i*DW +: DW] = t[7:0];
      end
      hs = a_valid && a_ready;
      @(negedge clk);
      if (hs) k++;
      budget++;
    end
    a_valid = 1'b0;
    if (k < vc) check("timeout_acts", 0, 1);
  endtask

  // One complete pass. abort_at >= 0 pulls reset while entry abort_at is on r_data.
  task automatic run_pass(input bit lw, input bit am, input int vc_drv, input bit stalls,
                          input int abort_at);
    int vc, k, budget;
    bit held, seen;
    logic [255:0] held_data;
    longint y;
    vc = (vc_drv > D) ? D : vc_drv;
    for (int kk = 0; kk < vc; kk++)
      for (int j = 0; j < N; j++) begin
        y = 0;
        for (int i = 0; i < N; i++) y += longint'(a_m[kk][i]) * longint'(w_m[i][j]);
        acc_m[kk][j] = ((am ? acc_m[kk][j] : 64'sd0) + y) & 64'h0000_0000_FFFF_FFFF;
      end

    @(negedge clk);
    start = 1'b1; load_w = lw; acc_mode = am; vec_count = vc_drv[4:0];
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (lw && vc > 0) send_weights(stalls);
    send_acts(vc, stalls);

    k = 0; budget = 0; held = 0; held_data = '0;
    while (k < vc && budget < 4000) begin
      r_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (held) begin
        check($sformatf("hold_valid k=%0d", k), r_valid, 1);
        check($sformatf("hold_data k=%0d", k), r_data, held_data);
      end
      if (abort_at >= 0 && k == abort_at && r_valid) begin
        rst = 1'b0; r_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        check("abort_busy", busy, 0);
        check("abort_r_valid", r_valid, 0);
        check("abort_r_data", r_data, 0);
        check("abort_done", done, 0);
        seen = 0;
        repeat (4) begin @(negedge clk); seen |= done; end
        check("abort_no_done_later", seen, 0);
        return;
      end
      if (r_valid && r_ready) begin
        check($sformatf("result k=%0d", k), r_data, exp_vec(k));
        check($sformatf("r_last k=%0d", k), r_last, (k == vc - 1));
        res[k]   = r_data;
        res18[k] = r_data18;
        k++;
        held = 0;
      end else begin
        held      = r_valid;
        held_data = r_data;
      end
      @(negedge clk);
      budget++;
    end
    r_ready = 1'b0;
    if (k < vc) check("timeout_drain", 0, 1);
    if (vc == 0) check("empty_no_r_valid", r_valid, 0);
    check("done_pulse", done, 1);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    logic [255:0] hv;
    #400_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] hv;
    do_reset();
    // Reset state.
    check("rst_w_ready", w_ready, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_last",  r_last,  0);
    check("rst_busy",    busy,    0);
    check("rst_done",    done,    0);
    check("rst_ovf",     ovf,     0);
    check("rst_r_data",  r_data,  0);

    // Identity tile: results echo the activations.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) w_m[i][j] = (i == j) ? 1 : 0;
    for (int i = 0; i < N; i++) begin a_m[0][i] = i + 1; a_m[1][i] = -(i + 1); end
    run_pass(1, 0, 2, 0, -1);
    for (int j = 0; j < N; j++) hv[j*AW +: AW] = j + 1;
    check("ident_v0", res[0], hv);
    for (int j = 0; j < N; j++) hv[j*AW +: AW] = -(j + 1);
    check("ident_v1", res[1], hv);

    // Largest positive operands: 8 * 127 * 127 per column.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) w_m[i][j] = 127;
      a_m[0][i] = 127;
    end
    run_pass(1, 0, 1, 0, -1);
    check("max_pos_v0", res[0], splat32(129032));
    check("max_pos_ovf", ovf, 0);

    // Overwrite pass then accumulate pass on the same tile: results double.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) w_m[i][j] = 1;
      a_m[0][i] = i + 1;
      a_m[1][i] = -3;
    end
    run_pass(1, 0, 2, 0, -1);
    check("dbl_p1_v0", res[0], splat32(36));
    check("dbl_p1_v1", res[1], splat32(-24));
    run_pass(0, 1, 2, 0, -1);
    check("dbl_p2_v0", res[0], splat32(72));
    check("dbl_p2_v1", res[1], splat32(-48));

    // Full-depth pass with random stalls on every stream.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) w_m[i][j] = $urandom_range(0, 255) - 128;
    for (int k = 0; k < D; k++) for (int i = 0; i < N; i++) a_m[k][i] = $urandom_range(0, 255) - 128;
    run_pass(1, 0, 16, 1, -1);

    // Count above depth is clamped; accumulates onto the previous pass.
    run_pass(0, 1, 20, 0, -1);

    // Empty pass: straight to FINISH.
    run_pass(0, 0, 0, 0, -1);

    // Reset while draining aborts without done.
    run_pass(0, 0, 3, 0, 1);

    // 18-bit accumulator: 8 * (-128 * -128) = 2^17 wraps to the most negative value.
    do_reset();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) w_m[i][j] = -128;
      a_m[0][i] = -128;
    end
    run_pass(1, 1, 1, 0, -1);
    check("ovf18_p1_data", res18[0], {8{18'h20000}});
    check("ovf18_p1_flag", ovf18, 0);
    check("wide_p1_data", res[0], splat32(131072));
    run_pass(0, 1, 1, 0, -1);
    check("ovf18_p2_data", res18[0], 144'd0);
    check("ovf18_p2_flag", ovf18, 1);
    check("wide_p2_data", res[0], splat32(262144));
    check("wide_p2_flag", ovf, 0);
    run_pass(0, 1, 1, 0, -1);
    check("ovf18_p3_data", res18[0], {8{18'h20000}});
    check("ovf18_p3_flag_cleared", ovf18, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
